// File: rtl/elevator_pkg.sv
// Shared types for the elevator simulation: motion state encoding and travel direction.
// vgaController imports sim_state_t so both blocks agree on the 2-bit state code.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR_OPEN = 2'b11
  } sim_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int MAX_FLOORS = 8;

endpackage

// File: rtl/elevator_dispatch_tick_timer.sv
// Loadable down-counter shared by the travel and door-dwell phases; done is high at zero.
// Load has priority over counting, and the count parks at zero rather than wrapping.
module tick_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/elevator_dispatch.sv
// SCAN car-motion sequencer: latches call pulses into a pending register, keeps moving in one
// direction while requests lie ahead, and times floor-to-floor travel and door dwell.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int FLOORS       = 8,
  parameter int TRAVEL_TICKS = 25_000_000,
  parameter int DOOR_TICKS   = 50_000_000,
  parameter int TIMER_W      = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLOORS-1:0]     call,
  output logic [1:0]            sim_state,
  output logic [MAX_FLOORS-1:0] destination,
  output logic [2:0]            current_floor,
  output logic [FLOORS-1:0]     pending
);

  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_TICKS - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_TICKS - 1);
  localparam logic [2:0]         TOP_FLOOR   = 3'(FLOORS - 1);

  function automatic logic [FLOORS-1:0] onehot(input logic [2:0] f);
    logic [FLOORS-1:0] res;
    for (int i = 0; i < FLOORS; i++) res[i] = (i == int'(f));
    return res;
  endfunction

  function automatic logic [FLOORS-1:0] mask_above(input logic [2:0] f);
    logic [FLOORS-1:0] res;
    for (int i = 0; i < FLOORS; i++) res[i] = (i > int'(f));
    return res;
  endfunction

  function automatic logic [FLOORS-1:0] mask_below(input logic [2:0] f);
    logic [FLOORS-1:0] res;
    for (int i = 0; i < FLOORS; i++) res[i] = (i < int'(f));
    return res;
  endfunction

  // Nearest request strictly above f: scan downward so the lowest qualifying bit wins.
  function automatic logic [FLOORS-1:0] pick_above(input logic [FLOORS-1:0] m,
                                                   input logic [2:0]        f);
    logic [FLOORS-1:0] res;
    res = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(f))) res = onehot(3'(i));
    end
    return res;
  endfunction

  function automatic logic [FLOORS-1:0] pick_below(input logic [FLOORS-1:0] m,
                                                   input logic [2:0]        f);
    logic [FLOORS-1:0] res;
    res = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (m[i] && (i < int'(f))) res = onehot(3'(i));
    end
    return res;
  endfunction

  // Floor the IDLE decision would head for next, given pending mask, floor and direction.
  function automatic logic [FLOORS-1:0] idle_target(input logic [FLOORS-1:0] m,
                                                    input logic [2:0]        f,
                                                    input dir_t              d);
    logic [FLOORS-1:0] up_pick, dn_pick;
    up_pick = pick_above(m, f);
    dn_pick = pick_below(m, f);
    if (|(m & onehot(f))) return onehot(f);
    if (d == DIR_UP)      return (|up_pick) ? up_pick : dn_pick;
    return (|dn_pick) ? dn_pick : up_pick;
  endfunction

  sim_state_t                state_q, state_d;
  dir_t                      dir_q, dir_d;
  logic [2:0]                floor_q, floor_d;
  logic [FLOORS-1:0]         pending_q, pending_d;
  logic [MAX_FLOORS-1:0]     dest_q, dest_d;
  logic [FLOORS-1:0]         clr, dest_f;
  logic [2:0]                next_floor;
  logic                      above, below, here;
  logic                      timer_load, timer_en, timer_done;
  logic [TIMER_W-1:0]        timer_val;

  assign above = |(pending_q & mask_above(floor_q));
  assign below = |(pending_q & mask_below(floor_q));
  assign here  = |(pending_q & onehot(floor_q));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    dir_d      = dir_q;
    floor_d    = floor_q;
    clr        = '0;
    timer_load = 1'b0;
    timer_val  = TRAVEL_LOAD;
    timer_en   = 1'b0;
    next_floor = floor_q;

    case (state_q)
      IDLE: begin
        if (here) begin
          state_d    = DOOR_OPEN;
          clr        = onehot(floor_q);
          timer_load = 1'b1;
          timer_val  = DOOR_LOAD;
        end else if ((dir_q == DIR_UP && above) || (dir_q == DIR_DOWN && !below && above)) begin
          state_d    = MOVE_UP;
          dir_d      = DIR_UP;
          timer_load = 1'b1;
        end else if (below) begin
          state_d    = MOVE_DOWN;
          dir_d      = DIR_DOWN;
          timer_load = 1'b1;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if ((state_q == MOVE_UP && floor_q == TOP_FLOOR) ||
            (state_q == MOVE_DOWN && floor_q == 3'd0)) begin
          state_d = IDLE;
        end else if (timer_done) begin
          next_floor = (state_q == MOVE_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
          floor_d    = next_floor;
          if (|(pending_q & onehot(next_floor))) begin
            state_d    = DOOR_OPEN;
            clr        = onehot(next_floor);
            timer_load = 1'b1;
            timer_val  = DOOR_LOAD;
          end else if ((state_q == MOVE_UP   && |(pending_q & mask_above(next_floor))) ||
                       (state_q == MOVE_DOWN && |(pending_q & mask_below(next_floor)))) begin
            timer_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_en = 1'b1;
        end
      end

      DOOR_OPEN: begin
        // Calls for the floor whose doors are open are absorbed, not queued.
        clr = onehot(floor_q);
        if (timer_done) state_d = IDLE;
        else            timer_en = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    pending_d = (pending_q | call) & ~clr;
  end

  always_comb begin
    case (state_d)
      MOVE_UP:   dest_f = pick_above(pending_d, floor_d);
      MOVE_DOWN: dest_f = pick_below(pending_d, floor_d);
      default:   dest_f = idle_target(pending_d, floor_d, dir_d);
    endcase
    dest_d             = '0;
    dest_d[FLOORS-1:0] = dest_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      floor_q   <= '0;
      pending_q <= '0;
      dest_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dest_q    <= dest_d;
    end
  end

  tick_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  assign sim_state     = state_q;
  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign destination   = dest_q;

endmodule

// File: tb/tb_elevator_dispatch.sv
// Scoreboard bench: stimulus pushes the expected state-change events (with cycle stamps),
// a monitor pops one per observed sim_state change and compares every output.
module tb_elevator_dispatch;

  localparam logic [1:0] S_IDLE = 2'b00, S_UP = 2'b01, S_DOWN = 2'b10, S_DOOR = 2'b11;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [2:0] fl;
    logic [7:0] pend;
    logic [7:0] dest;
  } ev_t;

  logic       clk, rst;
  logic [7:0] call;
  logic [1:0] sim_state;
  logic [7:0] destination;
  logic [2:0] current_floor;
  logic [7:0] pending;

  int   checks, failures, cyc, ev_n;
  bit   mon_en;
  logic [1:0] prev_state;
  ev_t  sb[$];

  elevator_dispatch #(
    .FLOORS(8), .TRAVEL_TICKS(4), .DOOR_TICKS(3), .TIMER_W(26)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .call          (call),
    .sim_state     (sim_state),
    .destination   (destination),
    .current_floor (current_floor),
    .pending       (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] st, input logic [2:0] fl,
                      input logic [7:0] pend, input logic [7:0] dest);
    ev_t e;
    e.cyc = c; e.st = st; e.fl = fl; e.pend = pend; e.dest = dest;
    sb.push_back(e);
  endtask

  // Drive a one-cycle call pulse from a negedge; p is the cycle of the sampling edge.
  task automatic pulse(input logic [7:0] mask, output int p);
    call = mask;
    @(negedge clk);
    p = cyc;
    call = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: every sim_state change must match the next queued event.
  always @(negedge clk) begin
    if (mon_en && (sim_state !== prev_state)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_transition: got state %0b floor %0d expected no change (cycle %0d)",
                 sim_state, current_floor, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        ev_n++;
        check($sformatf("ev%0d_state", ev_n), 32'(sim_state),     32'(e.st));
        check($sformatf("ev%0d_cycle", ev_n), 32'(cyc),           32'(e.cyc));
        check($sformatf("ev%0d_floor", ev_n), 32'(current_floor), 32'(e.fl));
        check($sformatf("ev%0d_pend",  ev_n), 32'(pending),       32'(e.pend));
        check($sformatf("ev%0d_dest",  ev_n), 32'(destination),   32'(e.dest));
      end
    end
    prev_state = sim_state;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int p, q;
    checks = 0; failures = 0; cyc = 0; ev_n = 0; mon_en = 1'b0;
    rst = 1'b1; call = '0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state",   32'(sim_state),     32'(S_IDLE));
    check("rst_floor",   32'(current_floor), 32'd0);
    check("rst_pending", 32'(pending),       32'd0);
    check("rst_dest",    32'(destination),   32'd0);
    mon_en = 1'b1;

    // Single call to floor 3 from floor 0.
    pulse(8'h08, p);
    check("t1_dest_next",  32'(destination), 32'h08);
    check("t1_pend_next",  32'(pending),     32'h08);
    check("t1_still_idle", 32'(sim_state),   32'(S_IDLE));
    push(p + 1,  S_UP,   3'd0, 8'h08, 8'h08);
    push(p + 13, S_DOOR, 3'd3, 8'h00, 8'h00);
    push(p + 16, S_IDLE, 3'd3, 8'h00, 8'h00);
    wait_drain(100);

    // SCAN: at floor 3 heading up, calls at 1 and 6 -> serve 6 then 1.
    pulse(8'h42, p);
    push(p + 1,  S_UP,   3'd3, 8'h42, 8'h40);
    push(p + 13, S_DOOR, 3'd6, 8'h02, 8'h02);
    push(p + 16, S_IDLE, 3'd6, 8'h02, 8'h02);
    push(p + 17, S_DOWN, 3'd6, 8'h02, 8'h02);
    push(p + 37, S_DOOR, 3'd1, 8'h00, 8'h00);
    push(p + 40, S_IDLE, 3'd1, 8'h00, 8'h00);
    wait_drain(100);

    // Return to floor 0 (direction stays down).
    pulse(8'h01, p);
    push(p + 1, S_DOWN, 3'd1, 8'h01, 8'h01);
    push(p + 5, S_DOOR, 3'd0, 8'h00, 8'h00);
    push(p + 8, S_IDLE, 3'd0, 8'h00, 8'h00);
    wait_drain(100);

    // Hall call on the way: 0 -> 5, floor 2 called while leaving floor 0.
    pulse(8'h20, p);
    push(p + 1,  S_UP,   3'd0, 8'h20, 8'h20);
    push(p + 9,  S_DOOR, 3'd2, 8'h20, 8'h20);
    push(p + 12, S_IDLE, 3'd2, 8'h20, 8'h20);
    push(p + 13, S_UP,   3'd2, 8'h20, 8'h20);
    push(p + 25, S_DOOR, 3'd5, 8'h00, 8'h00);
    push(p + 28, S_IDLE, 3'd5, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    pulse(8'h04, q);
    check("t3_dest_retarget", 32'(destination), 32'h04);
    check("t3_pend_both",     32'(pending),     32'h24);
    wait_drain(100);

    // Current-floor call during DOOR_OPEN at floor 4 is absorbed.
    pulse(8'h10, p);
    push(p + 1, S_DOWN, 3'd5, 8'h10, 8'h10);
    push(p + 5, S_DOOR, 3'd4, 8'h00, 8'h00);
    push(p + 8, S_IDLE, 3'd4, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    pulse(8'h10, q);
    check("t4_absorbed_pend", 32'(pending),   32'h00);
    check("t4_door_state",    32'(sim_state), 32'(S_DOOR));
    wait_drain(100);
    repeat (4) @(negedge clk);
    check("t4_idle_after", 32'(sim_state), 32'(S_IDLE));

    // Mid-move reset with three calls pending; a call during reset is lost.
    pulse(8'h07, p);
    push(p + 1, S_DOWN, 3'd4, 8'h07, 8'h04);
    @(negedge clk);
    push(p + 2, S_IDLE, 3'd0, 8'h00, 8'h00);
    rst = 1'b1;
    call = 8'h80;
    @(negedge clk);
    rst = 1'b0;
    call = '0;
    repeat (20) @(negedge clk);
    check("t5_state",   32'(sim_state),     32'(S_IDLE));
    check("t5_floor",   32'(current_floor), 32'd0);
    check("t5_pending", 32'(pending),       32'd0);
    check("t5_dest",    32'(destination),   32'd0);
    check("sb_empty",   32'(sb.size()),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
